// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary quadrature generator.
//   - State encoding for the detent FSM (idle plus four quadrature phases).
//   - Per-phase (A,B) levels for both rotation directions. Bit 1 is channel A
//     and bit 0 is channel B. Element [0] belongs to P1 and element [3] to P4.
//   - phase_levels(): returns the channel levels for a given state and direction.
package rotary_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_P1   = 3'd1;
    localparam logic [2:0] ST_P2   = 3'd2;
    localparam logic [2:0] ST_P3   = 3'd3;
    localparam logic [2:0] ST_P4   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_P1   = ST_P1,
        S_P2   = ST_P2,
        S_P3   = ST_P3,
        S_P4   = ST_P4
    } state_t;

    // The sequence is a Gray code: each step changes only one channel.
    localparam logic [3:0][1:0] CW_LEVELS  = {2'b00, 2'b01, 2'b11, 2'b10};
    localparam logic [3:0][1:0] CCW_LEVELS = {2'b00, 2'b10, 2'b11, 2'b01};

    function automatic logic [1:0] phase_levels(input state_t st, input logic cw);
        logic [2:0] offset;
        logic [1:0] levels;
        offset = st - ST_P1;
        if (st == S_IDLE) begin
            levels = 2'b00;
        end else if (cw) begin
            levels = CW_LEVELS[offset[1:0]];
        end else begin
            levels = CCW_LEVELS[offset[1:0]];
        end
        return levels;
    endfunction

endpackage

// File: rtl/rotary_phase_timer.sv
// Phase timer for the rotary quadrature generator.
// A modulo-PHASE_CYCLES counter. It runs while en_i is high and clears
// synchronously on clr_i, which the top asserts on every state change.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   clr_i        synchronous clear; it has priority over counting
//   en_i         count enable, high while a phase is being held
//   phase_end_o  high during the last cycle of a phase (count == PHASE_CYCLES-1)
module rotary_phase_timer #(
    parameter int PHASE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic phase_end_o
);

    // The counter is kept at least one bit wide so that PHASE_CYCLES=1 still works.
    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign phase_end_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = phase_end_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rotary_quadrature_generator.sv
// Rotary quadrature generator.
// Emits ROT_A/ROT_B quadrature waveforms, one full detent per step, from a
// start/steps/dir command.
// Ports:
//   clk, rst    system clock and synchronous active-high reset
//   start       command strobe; it is accepted only while idle
//   dir         1 = CW (A leads B), 0 = CCW (B leads A); latched on accept
//   steps       number of detents to emit; latched on accept
//   busy        high while a command is in progress
//   done        one-cycle pulse when a command completes (including steps=0)
//   step_tick   one-cycle pulse on entry into the A=B=1 phase
//   steps_left  detents remaining, including the one in progress
//   ROT_A/B     registered quadrature outputs
module rotary_quadrature_generator
    import rotary_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    output logic             busy,
    output logic             done,
    output logic             step_tick,
    output logic [CNT_W-1:0] steps_left,
    output logic             ROT_A,
    output logic             ROT_B
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] steps_left_q, steps_left_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic [1:0]       rot_q, rot_d;
    logic             phase_end;

    rotary_phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_d != state_q),
        .en_i       (state_q != S_IDLE),
        .phase_end_o(phase_end)
    );

    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tick_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d = dir;
                    if (steps != '0) begin
                        state_d      = S_P1;
                        steps_left_d = steps;
                        busy_d       = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_P1: begin
                if (phase_end) begin
                    state_d = S_P2;
                    tick_d  = 1'b1;
                end
            end
            S_P2: begin
                if (phase_end) begin
                    state_d = S_P3;
                end
            end
            S_P3: begin
                if (phase_end) begin
                    state_d = S_P4;
                end
            end
            S_P4: begin
                if (phase_end) begin
                    if (steps_left_q != '0) begin
                        steps_left_d = steps_left_q - CNT_W'(1);
                    end
                    // Compare the pre-decrement value: more than one detent
                    // left means another detent follows.
                    if (steps_left_q > CNT_W'(1)) begin
                        state_d = S_P1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The levels follow the next state, so the channels move on the same
        // edge as the state change and add no latency.
        rot_d = phase_levels(state_d, dir_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            steps_left_q <= '0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tick_q       <= 1'b0;
            rot_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tick_q       <= tick_d;
            rot_q        <= rot_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign step_tick  = tick_q;
    assign steps_left = steps_left_q;
    assign ROT_A      = rot_q[1];
    assign ROT_B      = rot_q[0];

endmodule

// File: tb/tb_rotary_quadrature_generator.sv
// Self-checking bench for rotary_quadrature_generator (PHASE_CYCLES=4, CNT_W=8).
// A time-indexed model predicts every output from the command accepted and the
// number of cycles since acceptance. Directed tests add literal checks.
module tb_rotary_quadrature_generator;

    localparam int P = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] steps = '0;
    logic         busy, done, step_tick, ROT_A, ROT_B;
    logic [W-1:0] steps_left;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    rotary_quadrature_generator #(.PHASE_CYCLES(P), .CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .steps     (steps),
        .busy      (busy),
        .done      (done),
        .step_tick (step_tick),
        .steps_left(steps_left),
        .ROT_A     (ROT_A),
        .ROT_B     (ROT_B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a running command is described only by its start parameters and
    // by k, the number of edges since the accepting edge.
    int m_mode = 0;
    int m_k = 0;
    int m_steps = 0;
    bit m_dir = 1'b0;
    bit m_done = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_mode = 0;
        end else if (m_mode != 0) begin
            m_k++;
            if (m_k == 4 * P * m_steps) begin
                m_mode = 0;
                m_done = 1'b1;
            end
        end else if (start) begin
            m_dir   = dir;
            m_steps = int'(steps);
            m_k     = 0;
            if (steps != 0) m_mode = 1;
            else m_done = 1'b1;
        end
    end

    logic [1:0] e_ab;
    int         e_sl, e_phase;
    logic       e_busy, e_tick;

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_mode != 0) begin
                e_phase = (m_k / P) % 4;
                case (e_phase)
                    0:       e_ab = m_dir ? 2'b10 : 2'b01;
                    1:       e_ab = 2'b11;
                    2:       e_ab = m_dir ? 2'b01 : 2'b10;
                    default: e_ab = 2'b00;
                endcase
                e_busy = 1'b1;
                e_sl   = m_steps - m_k / (4 * P);
                e_tick = ((m_k % (4 * P)) == P);
            end else begin
                e_ab   = 2'b00;
                e_busy = 1'b0;
                e_sl   = 0;
                e_tick = 1'b0;
            end
            chk("cyc_rot_ab", {30'd0, ROT_A, ROT_B}, {30'd0, e_ab});
            chk("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
            chk("cyc_step_tick", {31'd0, step_tick}, {31'd0, e_tick});
            chk("cyc_steps_left", {24'd0, steps_left}, e_sl);
        end
    end

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents a command for one edge and returns in the cycle after the
    // accepting edge. It then scrambles dir/steps to show they are ignored.
    task automatic issue(input bit d, input int s);
        start = 1'b1;
        dir   = d;
        steps = s[W-1:0];
        @(negedge clk);
        start = 1'b0;
        dir   = ~d;
        steps = 8'hA5;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ticks, busy_cnt, done_at, rises, dones;
        bit prev_a;

        // Power-on reset.
        step_n(2);
        chk_en = 1'b1;
        chk("por_rot", {30'd0, ROT_A, ROT_B}, 0);
        chk("por_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        step_n(1);
        $display("txn reset: done");

        // 1: reset held for 3 cycles in the middle of a command.
        issue(1'b1, 2);
        step_n(5);
        rst = 1'b1;
        step_n(1);
        chk("t1_rot_in_rst", {30'd0, ROT_A, ROT_B}, 0);
        chk("t1_busy_in_rst", {31'd0, busy}, 0);
        chk("t1_done_in_rst", {31'd0, done}, 0);
        chk("t1_sl_in_rst", {24'd0, steps_left}, 0);
        step_n(2);
        rst = 1'b0;
        step_n(1);
        chk("t1_rot_after", {30'd0, ROT_A, ROT_B}, 0);
        chk("t1_busy_after", {31'd0, busy}, 0);
        $display("txn mid-stream reset");

        // 2: CW, one detent.
        issue(1'b1, 1);
        chk("t2_e0_ab", {30'd0, ROT_A, ROT_B}, 2'b10);
        chk("t2_e0_sl", {24'd0, steps_left}, 1);
        step_n(4);
        chk("t2_e4_ab", {30'd0, ROT_A, ROT_B}, 2'b11);
        chk("t2_e4_tick", {31'd0, step_tick}, 1);
        step_n(1);
        chk("t2_e5_tick", {31'd0, step_tick}, 0);
        step_n(3);
        chk("t2_e8_ab", {30'd0, ROT_A, ROT_B}, 2'b01);
        step_n(4);
        chk("t2_e12_ab", {30'd0, ROT_A, ROT_B}, 2'b00);
        chk("t2_e12_busy", {31'd0, busy}, 1);
        step_n(4);
        chk("t2_e16_done", {31'd0, done}, 1);
        chk("t2_e16_busy", {31'd0, busy}, 0);
        step_n(1);
        chk("t2_e17_done", {31'd0, done}, 0);
        $display("txn CW steps=1");

        // 3: CCW, three detents.
        issue(1'b0, 3);
        ticks = 0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) busy_cnt++;
            if (step_tick) ticks++;
            if (i == 0) chk("t3_e0_ab", {30'd0, ROT_A, ROT_B}, 2'b01);
            if (i == 8) chk("t3_e8_ab", {30'd0, ROT_A, ROT_B}, 2'b10);
            if (i == 16) chk("t3_e16_sl", {24'd0, steps_left}, 2);
            if (i == 32) chk("t3_e32_sl", {24'd0, steps_left}, 1);
            if (i == 48) chk("t3_e48_sl", {24'd0, steps_left}, 0);
            step_n(1);
        end
        chk("t3_ticks", ticks, 3);
        chk("t3_busy_cycles", busy_cnt, 48);
        $display("txn CCW steps=3 ticks=%0d busy=%0d", ticks, busy_cnt);

        // 4: steps=0 completes immediately.
        issue(1'b1, 0);
        chk("t4_done", {31'd0, done}, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_rot", {30'd0, ROT_A, ROT_B}, 0);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step_n(1);
            if (busy) busy_cnt++;
        end
        chk("t4_busy_never", busy_cnt, 0);
        $display("txn steps=0");

        // 5: start during busy is ignored; start in the done cycle is accepted.
        issue(1'b1, 2);
        step_n(3);
        start = 1'b1;
        steps = 8'd5;
        step_n(1);
        start = 1'b0;
        ticks = 0;
        done_at = -1;
        for (int i = 4; i <= 40; i++) begin
            if (step_tick) ticks++;
            if (done) begin
                done_at = i;
                break;
            end
            step_n(1);
        end
        chk("t5_done_edge", done_at, 32);
        chk("t5_ticks", ticks, 2);
        start = 1'b1;
        dir   = 1'b0;
        steps = 8'd1;
        step_n(1);
        start = 1'b0;
        chk("t5_b2b_busy", {31'd0, busy}, 1);
        chk("t5_b2b_ab", {30'd0, ROT_A, ROT_B}, 2'b01);
        chk("t5_b2b_sl", {24'd0, steps_left}, 1);
        step_n(16);
        chk("t5_b2b_done", {31'd0, done}, 1);
        step_n(1);
        $display("txn ignored start, back-to-back done_at=%0d", done_at);

        // 6: loopback into a rotation-event detector (rising edges on A).
        prev_a = ROT_A;
        rises = 0;
        dones = 0;
        issue(1'b1, 7);
        for (int i = 0; i < 7 * 16 + 4; i++) begin
            if (ROT_A && !prev_a) rises++;
            prev_a = ROT_A;
            if (done) dones++;
            step_n(1);
        end
        chk("t6_rises", rises, 7);
        chk("t6_dones", dones, 1);
        issue(1'b0, 4);
        step_n(19);
        rst = 1'b1;
        step_n(1);
        rst = 1'b0;
        chk("t6_rst_rot", {30'd0, ROT_A, ROT_B}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_done", {31'd0, done}, 0);
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) dones++;
            step_n(1);
        end
        chk("t6_no_done_after_abort", dones, 0);
        $display("txn loopback rises=%0d, abort", rises);

        // Boundary: maximum step count.
        issue(1'b0, 255);
        chk("tmax_sl", {24'd0, steps_left}, 255);
        busy_cnt = 0;
        for (int i = 0; i < 4200; i++) begin
            if (!busy) break;
            busy_cnt++;
            step_n(1);
        end
        chk("tmax_busy_cycles", busy_cnt, 4080);
        chk("tmax_done", {31'd0, done}, 1);
        step_n(2);
        $display("txn steps=255 busy=%0d", busy_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
